// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a byte stream (16-bit word count,
// little-endian 32-bit words, optional XOR checksum) into instruction memory
// writes. It holds the core in reset until the image has been fully written.
// Optional feature macro: LOADER_CHECKSUM_EN adds the trailing checksum byte.
//
// Stream handshake: a byte moves on a rising clk edge where in_valid and
// in_ready are both high. in_valid may drop at any time; the partial word
// and byte lane simply hold. in_ready depends only on loader state and never
// drops because of a memory write.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_err,
  output logic [2:0]            dbg_state
);

  localparam int IW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                r_state;
  logic [15:0]           r_count;
  logic [IW-1:0]         r_word_idx;
  logic [1:0]            r_lane;
  logic [23:0]           r_word;
  logic                  r_fin;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_core_rst_n;
  logic                  r_done;
  logic                  r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_chk;
`endif

  logic        w_accept;
  logic [15:0] w_count_full;
  logic [15:0] w_idx_next;
  logic        w_last_word;

  assign w_accept     = in_valid & r_ready;
  assign w_count_full = {in_data, r_count[7:0]};
  assign w_idx_next   = 16'(r_word_idx) + 16'd1;
  assign w_last_word  = (w_idx_next == r_count);

  assign in_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign dbg_state  = r_state;

  // Loader FSM: header, word assembly, memory write strobe and status.
  // After the last byte r_fin spends one cycle before DONE so the final
  // write strobe completes before the core is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LEN_LO;
      r_count      <= 16'd0;
      r_word_idx   <= '0;
      r_lane       <= 2'd0;
      r_word       <= 24'd0;
      r_fin        <= 1'b0;
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chk        <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
      if (r_fin) begin
        r_fin   <= 1'b0;
        r_state <= S_DONE;
      end else begin
        case (r_state)
          S_LEN_LO: begin
            r_ready <= 1'b1;
            if (w_accept) begin
              r_count <= {8'h00, in_data};
              r_state <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (w_accept) begin
              r_count <= w_count_full;
              if (w_count_full > 16'(MAX_WORDS)) begin
                r_state <= S_ERR;
                r_ready <= 1'b0;
              end else if (w_count_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CHK;
`else
                r_fin   <= 1'b1;
                r_ready <= 1'b0;
`endif
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_accept) begin
              r_lane <= r_lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
              r_chk  <= r_chk ^ in_data;
`endif
              case (r_lane)
                2'd0: r_word[7:0]   <= in_data;
                2'd1: r_word[15:8]  <= in_data;
                2'd2: r_word[23:16] <= in_data;
                default: begin
                  r_wdata    <= {in_data, r_word};
                  r_addr     <= ADDR_WIDTH'({r_word_idx, 2'b00});
                  r_we       <= 1'b1;
                  r_word_idx <= r_word_idx + IW'(1);
                  if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    r_state <= S_CHK;
`else
                    r_fin   <= 1'b1;
                    r_ready <= 1'b0;
`endif
                  end
                end
              endcase
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHK: begin
            if (w_accept) begin
              r_ready <= 1'b0;
              if (in_data == r_chk) r_fin <= 1'b1;
              else                  r_state <= S_ERR;
            end
          end
`endif
          S_DONE: begin
            r_ready      <= 1'b0;
            r_done       <= 1'b1;
            r_core_rst_n <= 1'b1;
          end
          S_ERR: begin
            r_ready      <= 1'b0;
            r_err        <= 1'b1;
            r_core_rst_n <= 1'b0;
          end
          default: begin
            r_state <= S_ERR;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test-plan images plus randomized images, checked
// against a byte-stream model (expected write queue, XOR checksum, outcome).
module tb_imem_loader;

  localparam int AW   = 10;
  localparam int MAXW = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;
  logic [2:0]    dbg_state;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int n_writes;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    img[$];
  logic           prev_we;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  initial prev_we = 1'b0;
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      n_writes++;
      check("we_gap", 64'(prev_we), 64'(0));
      check("write_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e[AW+31:32]));
        check("wr_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
    prev_we <= imem_we;
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_vals", 64'({in_ready, imem_we, core_rst_n, load_done, load_err}), 64'(0));
    check("rst_addr_data", 64'({imem_addr, imem_wdata}), 64'(0));
    idle(2);
    rst_n = 1'b1;
    #1 check("rdy_at_release", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 check("rdy_after_release", 64'(in_ready), 64'(1));
  endtask

  // Send an image of cnt words from img[]; optional idle gap before data
  // byte number gap_at; bad_chk corrupts the checksum byte.
  task automatic run_image(input int cnt, input bit bad_chk, input int gap_at, input int gap_len);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] c16;
    int w0;
    bit over;
    bit exp_err;
    x    = 8'h00;
    w0   = n_writes;
    over = (cnt > MAXW);
    c16  = 16'(cnt);
    if (!over)
      for (int i = 0; i < cnt; i++) exp_q.push_back({AW'(4 * i), img[i]});
    send_byte(c16[7:0]);
    send_byte(c16[15:8]);
    if (!over) begin
      for (int i = 0; i < cnt; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (i * 4 + k == gap_at) idle(gap_len);
          b = img[i][8*k +: 8];
          x = x ^ b;
          send_byte(b);
          if (k == 3) check("we_latency", 64'(imem_we), 64'(1));
          if (k == 0) check("we_pulse_end", 64'(imem_we), 64'(0));
        end
      end
      if (CHK_EN) send_byte(bad_chk ? (x ^ 8'h01) : x);
    end
    exp_err = over || (CHK_EN && bad_chk);
    @(negedge clk);
    check("rdy_drop", 64'(in_ready), 64'(0));
    check("status_n", 64'({load_done, load_err, core_rst_n}), 64'(0));
    @(negedge clk);
    check("err_n1", 64'(load_err), 64'(exp_err));
    check("done_n1", 64'({load_done, core_rst_n}), 64'(0));
    @(negedge clk);
    check("done_n2", 64'(load_done), 64'(!exp_err));
    check("core_rst_n2", 64'(core_rst_n), 64'(!exp_err));
    check("err_n2", 64'(load_err), 64'(exp_err));
    check("rdy_term", 64'(in_ready), 64'(0));
    idle(3);
    check("write_count", 64'(n_writes - w0), 64'(over ? 0 : cnt));
    check("pending_writes", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int cnt;
    int gap_at;
    int gap_len;
    bit bad;
    n_tests  = 0;
    n_fail   = 0;
    n_writes = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // three-word image, back-to-back
    do_reset();
    img = '{32'h00A00093, 32'h00108113, 32'h002081B3};
    run_image(3, 1'b0, -1, 0);

    // same image with a 5-cycle stall mid-word
    do_reset();
    run_image(3, 1'b0, 6, 5);

    // empty image
    do_reset();
    run_image(0, 1'b0, -1, 0);

    // over-length count
    do_reset();
    run_image(MAXW + 1, 1'b0, -1, 0);

`ifdef LOADER_CHECKSUM_EN
    // checksum mismatch after one write
    do_reset();
    img = '{32'h00000013};
    run_image(1, 1'b1, -1, 0);
`endif

    // reset in the middle of a 3-word load, then full reload
    do_reset();
    img = '{32'h00A00093, 32'h00108113, 32'h002081B3};
    for (int i = 0; i < 3; i++) exp_q.push_back({AW'(4 * i), img[i]});
    send_byte(8'd3);
    send_byte(8'd0);
    for (int j = 0; j < 6; j++) send_byte(img[j / 4][8*(j % 4) +: 8]);
    idle(1);
    check("mid_pending", 64'(exp_q.size()), 64'(2));
    exp_q.delete();
    do_reset();
    run_image(3, 1'b0, -1, 0);

    // largest legal image
    do_reset();
    img.delete();
    for (int i = 0; i < MAXW; i++) img.push_back($urandom);
    run_image(MAXW, 1'b0, -1, 0);

    // randomized images
    for (int r = 0; r < 12; r++) begin
      cnt = $urandom_range(1, 12);
      img.delete();
      for (int i = 0; i < cnt; i++) img.push_back($urandom);
      gap_at  = $urandom_range(0, 4 * cnt - 1);
      gap_len = $urandom_range(0, 4);
      bad     = CHK_EN && ($urandom_range(0, 1) == 1);
      do_reset();
      run_image(cnt, bad, gap_at, gap_len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
